pc_stack_unit: RTL
==================

// Module: pc_stack_unit
// PURPOSE
//   Parametrised program counter with sequential increment, absolute load, PC-relative
//   branch, stall and a DEPTH-entry hardware call/return stack.
//   Sits at the fetch stage and drives the instruction-memory address every cycle.
//   Successor to the fixed-width reset/load PC register: adds width, stride, branch,
//   subroutine linkage and error/status reporting.
// PARAMETERS
//   WIDTH        8   PC and address width in bits
//   RESET_VECTOR 0   PC value after reset (WIDTH bits)
//   STEP         1   sequential increment stride
//   DEPTH        4   return-stack entries (>=1)
// PORTS
//   clk        in   1      rising-edge clock; the block's only clock
//   reset      in   1      synchronous, active-high reset
//   en         in   1      1 = advance/execute command, 0 = stall (everything holds)
//   load       in   1      absolute jump to load_addr
//   load_addr  in   WIDTH  jump/call target
//   branch     in   1      relative branch: pc + offset
//   offset     in   WIDTH  two's-complement branch offset
//   call       in   1      push pc+STEP, jump to load_addr
//   ret        in   1      pop top of stack into pc
//   pc         out  WIDTH  current program counter (registered)
//   stack_full out  1      count == DEPTH
//   stack_empty out 1      count == 0
//   stack_err  out  1      sticky: push-when-full or pop-when-empty occurred
//   wrap       out  1      registered 1-cycle pulse: last sequential increment overflowed
// BEHAVIOUR
//   - All state updates on posedge clk; reset is synchronous, active-high.
//   - Reset: pc=RESET_VECTOR, count=0, stack_err=0, wrap=0; stack_empty=1, stack_full=0.
//     Reset overrides every other input, including a command mid-call/return.
//     Stack contents after reset are don't-care.
//   - Command priority when en=1: ret > call > load > branch > increment.
//     Lower-priority strobes asserted together with a higher one are ignored.
//   - en=0: pc, stack, count and stack_err hold; wrap=0; all strobes ignored.
//   - Increment: pc <= (pc+STEP) mod 2^WIDTH.
//     wrap=1 next cycle iff the unsigned sum carried out; 0 after every other command.
//   - load:   pc <= load_addr.
//   - branch: pc <= (pc + offset) mod 2^WIDTH; offset is sign-interpreted, wrap not flagged.
//   - call, count<DEPTH:  stack[count] <= (pc+STEP) mod 2^WIDTH, count++, pc <= load_addr.
//   - call, count==DEPTH: no push, pc holds, stack_err <= 1.
//   - ret, count>0:  pc <= stack[count-1], count--.
//   - ret, count==0: pc holds, stack_err <= 1.
//   - stack_err clears only on reset.
//   - stack_full/stack_empty: combinational decode of the registered count.
//   - Latency: the new pc is visible in the cycle after the command edge.
//     Stack is LIFO; count ranges 0..DEPTH.
// TESTING (WIDTH=8, STEP=1, DEPTH=4, RESET_VECTOR=0 unless stated)
//   1 reset=1 for 1 clk with call=1 -> pc=0x00, stack_empty=1, stack_err=0, wrap=0.
//   2 load 0xFE, then 2 idle clks -> pc 0xFF, then 0x00 with wrap=1 for exactly 1 cycle.
//   3 pc=0x10, branch with offset=0xFE -> pc=0x0E; pc=0xF0, offset=0x20 -> pc=0x10, wrap=0.
//   4 pc=0x20, call load_addr=0x80; then ret -> pc 0x80, then 0x21; stack_empty=1 after ret.
//   5 5 calls from empty -> 4 pushes, stack_full=1; 5th: pc holds, stack_err=1;
//     4 rets restore the pushed values in reverse order.
//   6 ret on empty -> pc holds, stack_err=1.
//     en=0 with load=1 -> pc unchanged.
//     call+ret together -> ret wins.
//     Reset mid-sequence -> count=0, stack_err=0.

Source files
------------

// File: rtl/pc_stack_unit.sv
// Fetch-stage program counter with sequential step, absolute load, relative branch,
// stall and a DEPTH-entry LIFO return stack with sticky misuse reporting.
module pc_stack_unit #(
  parameter int unsigned WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned STEP         = 1,
  parameter int unsigned DEPTH        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_addr,
  input  logic             branch,
  input  logic [WIDTH-1:0] offset,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err,
  output logic             wrap
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] stack_q [2**AW];

  logic [WIDTH:0]   inc_sum_s;
  logic [AW-1:0]    top_idx_s;
  logic [AW-1:0]    push_idx_s;
  logic             push_s;
  logic             full_s;
  logic             empty_s;

  // Carry out of the widened sum is the sequential-overflow indication
  assign inc_sum_s  = {1'b0, pc_q} + (WIDTH+1)'(STEP);
  assign top_idx_s  = AW'(count_q - CW'(1));
  assign push_idx_s = AW'(count_q);
  assign full_s     = (count_q == CW'(DEPTH));
  assign empty_s    = (count_q == CW'(0));

  // Next-state selection in priority order ret > call > load > branch > increment
  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    err_d   = err_q;
    wrap_d  = 1'b0;
    push_s  = 1'b0;
    if (en) begin
      if (ret) begin
        if (!empty_s) begin
          pc_d    = stack_q[top_idx_s];
          count_d = count_q - CW'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (call) begin
        if (!full_s) begin
          push_s  = 1'b1;
          pc_d    = load_addr;
          count_d = count_q + CW'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (load) begin
        pc_d = load_addr;
      end else if (branch) begin
        pc_d = pc_q + offset;
      end else begin
        pc_d   = inc_sum_s[WIDTH-1:0];
        wrap_d = inc_sum_s[WIDTH];
      end
    end else begin
      wrap_d = 1'b0;
    end
  end

  // Control state: pc, occupancy, sticky error and wrap pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VECTOR;
      count_q <= CW'(0);
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
    end
  end

  // Return-address storage; contents are meaningless after reset so no clear
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      stack_q[push_idx_s] <= inc_sum_s[WIDTH-1:0];
    end
  end

  assign pc          = pc_q;
  assign stack_err   = err_q;
  assign wrap        = wrap_q;
  assign stack_full  = full_s;
  assign stack_empty = empty_s;

endmodule
